// File: rtl/itcm_arbt_pkg.sv
// Shared widths and encodings for the ITCM arbiter.
// Address and data widths, owner codes and arbiter state codes live here.
package itcm_arbt_pkg;

    localparam int unsigned ITCM_ADDR_WIDTH = 16;
    localparam int unsigned ITCM_RAM_DW     = 32;
    localparam int unsigned ITCM_RAM_MW     = ITCM_RAM_DW / 8;

    typedef enum logic {
        ITCM_OWNER_IFU = 1'b0,
        ITCM_OWNER_LSU = 1'b1
    } itcm_owner_e;

    typedef enum logic {
        ITCM_ARB_IDLE = 1'b0,
        ITCM_ARB_BUSY = 1'b1
    } itcm_arb_state_e;

endpackage

// File: rtl/itcm_arbt.sv
// ITCM arbiter: shares one ITCM port between IFU (read-only) and LSU,
// one outstanding transaction, LSU priority with IFU anti-starvation.
module itcm_arbt
    import itcm_arbt_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       ifu2itcm_cmd_valid,
    output logic                       ifu2itcm_cmd_ready,
    input  logic [ITCM_ADDR_WIDTH-1:0] ifu2itcm_cmd_addr,
    output logic                       ifu2itcm_rsp_valid,
    input  logic                       ifu2itcm_rsp_ready,
    output logic [ITCM_RAM_DW-1:0]     ifu2itcm_rsp_rdata,

    input  logic                       lsu2itcm_cmd_valid,
    output logic                       lsu2itcm_cmd_ready,
    input  logic [ITCM_ADDR_WIDTH-1:0] lsu2itcm_cmd_addr,
    input  logic                       lsu2itcm_cmd_read,
    input  logic [ITCM_RAM_DW-1:0]     lsu2itcm_cmd_wdata,
    input  logic [ITCM_RAM_MW-1:0]     lsu2itcm_cmd_wmask,
    output logic                       lsu2itcm_rsp_valid,
    input  logic                       lsu2itcm_rsp_ready,
    output logic [ITCM_RAM_DW-1:0]     lsu2itcm_rsp_rdata,

    output logic                       itcm_cmd_valid,
    input  logic                       itcm_cmd_ready,
    output logic [ITCM_ADDR_WIDTH-1:0] itcm_cmd_addr,
    output logic                       itcm_cmd_read,
    output logic [ITCM_RAM_DW-1:0]     itcm_cmd_wdata,
    output logic [ITCM_RAM_MW-1:0]     itcm_cmd_wmask,
    input  logic                       itcm_rsp_valid,
    output logic                       itcm_rsp_ready,
    input  logic [ITCM_RAM_DW-1:0]     itcm_rsp_rdata
);

    localparam int unsigned CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIM);

    itcm_arb_state_e state_q, state_d;
    itcm_owner_e     owner_q, owner_d;
    logic [CW-1:0]   starve_q, starve_d;

    logic busy;
    logic owner_rsp_ready;
    logic rsp_hsk;
    logic cmd_allow;
    logic ifu_win;
    logic lsu_win;
    logic cmd_hsk;

    // Arbitration and handshake qualification
    always_comb begin
        busy            = (state_q == ITCM_ARB_BUSY);
        owner_rsp_ready = (owner_q == ITCM_OWNER_LSU) ? lsu2itcm_rsp_ready : ifu2itcm_rsp_ready;
        rsp_hsk         = busy & itcm_rsp_valid & owner_rsp_ready;
        cmd_allow       = rst_n & (~busy | rsp_hsk);
        ifu_win         = ifu2itcm_cmd_valid & (~lsu2itcm_cmd_valid | (starve_q == STARVE_MAX));
        lsu_win         = lsu2itcm_cmd_valid & ~ifu_win;
        cmd_hsk         = cmd_allow & (ifu_win | lsu_win) & itcm_cmd_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ITCM_ARB_IDLE;
            owner_q  <= ITCM_OWNER_IFU;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;

        if (cmd_hsk) begin
            state_d = ITCM_ARB_BUSY;
            owner_d = lsu_win ? ITCM_OWNER_LSU : ITCM_OWNER_IFU;
        end else if (rsp_hsk) begin
            state_d = ITCM_ARB_IDLE;
        end

        // Counts LSU wins that happened while IFU was left waiting
        if (!ifu2itcm_cmd_valid) begin
            starve_d = '0;
        end else if (cmd_hsk && ifu_win) begin
            starve_d = '0;
        end else if (cmd_hsk && lsu_win && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_comb begin
        itcm_cmd_valid     = cmd_allow & (ifu2itcm_cmd_valid | lsu2itcm_cmd_valid);
        ifu2itcm_cmd_ready = cmd_allow & ifu_win & itcm_cmd_ready;
        lsu2itcm_cmd_ready = cmd_allow & lsu_win & itcm_cmd_ready;

        itcm_cmd_addr  = lsu_win ? lsu2itcm_cmd_addr  : ifu2itcm_cmd_addr;
        itcm_cmd_read  = lsu_win ? lsu2itcm_cmd_read  : 1'b1;
        itcm_cmd_wdata = lsu_win ? lsu2itcm_cmd_wdata : '0;
        itcm_cmd_wmask = lsu_win ? lsu2itcm_cmd_wmask : '0;

        itcm_rsp_ready     = busy & owner_rsp_ready;
        ifu2itcm_rsp_valid = busy & (owner_q == ITCM_OWNER_IFU) & itcm_rsp_valid;
        lsu2itcm_rsp_valid = busy & (owner_q == ITCM_OWNER_LSU) & itcm_rsp_valid;
        ifu2itcm_rsp_rdata = (owner_q == ITCM_OWNER_IFU) ? itcm_rsp_rdata : '0;
        lsu2itcm_rsp_rdata = (owner_q == ITCM_OWNER_LSU) ? itcm_rsp_rdata : '0;
    end

endmodule

// File: tb/tb_itcm_arbt.sv
// Scoreboard bench for itcm_arbt: directed stimulus pushes expected ITCM
// commands and responses; a negedge monitor pops and compares them.
module tb_itcm_arbt;
    import itcm_arbt_pkg::*;

    typedef struct packed {
        logic        lsu_gnt;
        logic        ifu_gnt;
        logic [15:0] addr;
        logic        rd;
        logic [31:0] wd;
        logic [3:0]  wm;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        ifu2itcm_cmd_valid = 1'b0;
    logic        ifu2itcm_cmd_ready;
    logic [15:0] ifu2itcm_cmd_addr = '0;
    logic        ifu2itcm_rsp_valid;
    logic        ifu2itcm_rsp_ready = 1'b1;
    logic [31:0] ifu2itcm_rsp_rdata;

    logic        lsu2itcm_cmd_valid = 1'b0;
    logic        lsu2itcm_cmd_ready;
    logic [15:0] lsu2itcm_cmd_addr = '0;
    logic        lsu2itcm_cmd_read = 1'b1;
    logic [31:0] lsu2itcm_cmd_wdata = '0;
    logic [3:0]  lsu2itcm_cmd_wmask = '0;
    logic        lsu2itcm_rsp_valid;
    logic        lsu2itcm_rsp_ready = 1'b1;
    logic [31:0] lsu2itcm_rsp_rdata;

    logic        itcm_cmd_valid;
    logic        itcm_cmd_ready = 1'b1;
    logic [15:0] itcm_cmd_addr;
    logic        itcm_cmd_read;
    logic [31:0] itcm_cmd_wdata;
    logic [3:0]  itcm_cmd_wmask;
    logic        itcm_rsp_valid = 1'b0;
    logic        itcm_rsp_ready;
    logic [31:0] itcm_rsp_rdata = '0;

    int n_vec = 0;
    int n_err = 0;
    int n_cmd_hs = 0;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_ifu_rsp[$];
    logic [31:0] exp_lsu_rsp[$];

    logic        cmd_hs_s = 1'b0;
    logic        rsp_hs_s = 1'b0;
    logic [15:0] cmd_addr_s = '0;

    itcm_arbt #(.STARVE_LIM(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ifu2itcm_cmd_valid (ifu2itcm_cmd_valid),
        .ifu2itcm_cmd_ready (ifu2itcm_cmd_ready),
        .ifu2itcm_cmd_addr  (ifu2itcm_cmd_addr),
        .ifu2itcm_rsp_valid (ifu2itcm_rsp_valid),
        .ifu2itcm_rsp_ready (ifu2itcm_rsp_ready),
        .ifu2itcm_rsp_rdata (ifu2itcm_rsp_rdata),
        .lsu2itcm_cmd_valid (lsu2itcm_cmd_valid),
        .lsu2itcm_cmd_ready (lsu2itcm_cmd_ready),
        .lsu2itcm_cmd_addr  (lsu2itcm_cmd_addr),
        .lsu2itcm_cmd_read  (lsu2itcm_cmd_read),
        .lsu2itcm_cmd_wdata (lsu2itcm_cmd_wdata),
        .lsu2itcm_cmd_wmask (lsu2itcm_cmd_wmask),
        .lsu2itcm_rsp_valid (lsu2itcm_rsp_valid),
        .lsu2itcm_rsp_ready (lsu2itcm_rsp_ready),
        .lsu2itcm_rsp_rdata (lsu2itcm_rsp_rdata),
        .itcm_cmd_valid     (itcm_cmd_valid),
        .itcm_cmd_ready     (itcm_cmd_ready),
        .itcm_cmd_addr      (itcm_cmd_addr),
        .itcm_cmd_read      (itcm_cmd_read),
        .itcm_cmd_wdata     (itcm_cmd_wdata),
        .itcm_cmd_wmask     (itcm_cmd_wmask),
        .itcm_rsp_valid     (itcm_rsp_valid),
        .itcm_rsp_ready     (itcm_rsp_ready),
        .itcm_rsp_rdata     (itcm_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    function automatic cmd_t mk_cmd(input logic lsu, input logic [15:0] a, input logic rd,
                                    input logic [31:0] wd, input logic [3:0] wm);
        cmd_t c;
        c.lsu_gnt = lsu;
        c.ifu_gnt = ~lsu;
        c.addr    = a;
        c.rd      = rd;
        c.wd      = wd;
        c.wm      = wm;
        return c;
    endfunction

    function automatic logic [31:0] rdata_of(input logic [15:0] a);
        return (a == 16'h0010) ? 32'h0000_0013 : {16'hC0DE, a};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        cmd_t act;
        cmd_hs_s   = rst_n && itcm_cmd_valid && itcm_cmd_ready;
        rsp_hs_s   = rst_n && itcm_rsp_valid && itcm_rsp_ready;
        cmd_addr_s = itcm_cmd_addr;
        if (rst_n) begin
            if (cmd_hs_s) begin
                n_cmd_hs++;
                act = '{lsu_gnt: lsu2itcm_cmd_ready, ifu_gnt: ifu2itcm_cmd_ready,
                        addr: itcm_cmd_addr, rd: itcm_cmd_read,
                        wd: itcm_cmd_wdata, wm: itcm_cmd_wmask};
                if (exp_cmd.size() == 0) fail_now("cmd_unexpected");
                else check("cmd", 64'(act), 64'(exp_cmd.pop_front()));
            end
            if (ifu2itcm_rsp_valid && lsu2itcm_rsp_valid) fail_now("rsp_both_valid");
            if (ifu2itcm_rsp_valid && ifu2itcm_rsp_ready) begin
                if (exp_ifu_rsp.size() == 0) fail_now("ifu_rsp_unexpected");
                else check("ifu_rsp", 64'(ifu2itcm_rsp_rdata), 64'(exp_ifu_rsp.pop_front()));
            end
            if (lsu2itcm_rsp_valid && lsu2itcm_rsp_ready) begin
                if (exp_lsu_rsp.size() == 0) fail_now("lsu_rsp_unexpected");
                else check("lsu_rsp", 64'(lsu2itcm_rsp_rdata), 64'(exp_lsu_rsp.pop_front()));
            end
        end
    end

    // ITCM model: answers one cycle after each accepted command, holds until taken
    always @(posedge clk) begin
        #1;
        if (cmd_hs_s) begin
            itcm_rsp_valid = 1'b1;
            itcm_rsp_rdata = rdata_of(cmd_addr_s);
        end else if (rsp_hs_s) begin
            itcm_rsp_valid = 1'b0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic ifu_stream(input int unsigned n, input logic [15:0] base);
        for (int unsigned i = 0; i < n; i++) begin
            bit ok;
            ifu2itcm_cmd_valid = 1'b1;
            ifu2itcm_cmd_addr  = base + 16'(4 * i);
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                ok = ifu2itcm_cmd_ready;
            end
            if (!ok) fail_now("ifu_cmd_timeout");
            step();
        end
        ifu2itcm_cmd_valid = 1'b0;
    endtask

    task automatic lsu_stream(input int unsigned n, input logic [15:0] base, input logic rd,
                              input logic [31:0] wd, input logic [3:0] wm);
        for (int unsigned i = 0; i < n; i++) begin
            bit ok;
            lsu2itcm_cmd_valid = 1'b1;
            lsu2itcm_cmd_addr  = base + 16'(4 * i);
            lsu2itcm_cmd_read  = rd;
            lsu2itcm_cmd_wdata = wd;
            lsu2itcm_cmd_wmask = wm;
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                ok = lsu2itcm_cmd_ready;
            end
            if (!ok) fail_now("lsu_cmd_timeout");
            step();
        end
        lsu2itcm_cmd_valid = 1'b0;
    endtask

    function automatic logic [5:0] quiet_vec();
        return {itcm_cmd_valid, itcm_rsp_ready, ifu2itcm_cmd_ready,
                ifu2itcm_rsp_valid, lsu2itcm_cmd_ready, lsu2itcm_rsp_valid};
    endfunction

    initial begin
        // Reset: requests present but every handshake output must stay low
        ifu2itcm_cmd_valid = 1'b1;
        lsu2itcm_cmd_valid = 1'b1;
        #3;
        check("reset_outputs", 64'(quiet_vec()), 64'd0);
        ifu2itcm_cmd_valid = 1'b0;
        lsu2itcm_cmd_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 64'(quiet_vec()), 64'd0);
        step();

        // IFU-only fetch, accepted in the request cycle, data back next cycle
        exp_cmd.push_back(mk_cmd(1'b0, 16'h0010, 1'b1, 32'h0, 4'h0));
        exp_ifu_rsp.push_back(32'h0000_0013);
        ifu2itcm_cmd_valid = 1'b1;
        ifu2itcm_cmd_addr  = 16'h0010;
        @(negedge clk);
        check("t1_ifu_ready", 64'(ifu2itcm_cmd_ready), 64'd1);
        check("t1_lsu_ready", 64'(lsu2itcm_cmd_ready), 64'd0);
        step();
        ifu2itcm_cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_ifu_rsp_valid", 64'(ifu2itcm_rsp_valid), 64'd1);
        check("t1_lsu_rsp_valid", 64'(lsu2itcm_rsp_valid), 64'd0);
        repeat (3) step();

        // Downstream not ready: command held, no grant handshake
        itcm_cmd_ready = 1'b0;
        exp_cmd.push_back(mk_cmd(1'b1, 16'h0080, 1'b1, 32'h0, 4'h0));
        exp_lsu_rsp.push_back(32'hC0DE_0080);
        fork
            lsu_stream(1, 16'h0080, 1'b1, 32'h0, 4'h0);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("t2_hold_valid", 64'(itcm_cmd_valid), 64'd1);
                    check("t2_hold_ready", 64'(lsu2itcm_cmd_ready), 64'd0);
                    check("t2_hold_addr", 64'(itcm_cmd_addr), 64'h0080);
                end
                step();
                itcm_cmd_ready = 1'b1;
            end
        join
        repeat (3) step();

        // Simultaneous requests: LSU write wins, IFU follows back-to-back
        exp_cmd.push_back(mk_cmd(1'b1, 16'h0020, 1'b0, 32'hDEAD_BEEF, 4'hF));
        exp_cmd.push_back(mk_cmd(1'b0, 16'h0030, 1'b1, 32'h0, 4'h0));
        exp_lsu_rsp.push_back(32'hC0DE_0020);
        exp_ifu_rsp.push_back(32'hC0DE_0030);
        fork
            lsu_stream(1, 16'h0020, 1'b0, 32'hDEAD_BEEF, 4'hF);
            ifu_stream(1, 16'h0030);
            begin
                @(negedge clk);
                check("t3_ifu_ready", 64'(ifu2itcm_cmd_ready), 64'd0);
                check("t3_cmd_read", 64'(itcm_cmd_read), 64'd0);
                check("t3_lsu_ready", 64'(lsu2itcm_cmd_ready), 64'd1);
            end
        join
        repeat (3) step();

        // Both streaming: LSU x4 then IFU, one command per cycle
        for (int i = 0; i < 4; i++) exp_cmd.push_back(mk_cmd(1'b1, 16'h0100 + 16'(4 * i), 1'b1, 32'h0, 4'h0));
        exp_cmd.push_back(mk_cmd(1'b0, 16'h0200, 1'b1, 32'h0, 4'h0));
        for (int i = 4; i < 8; i++) exp_cmd.push_back(mk_cmd(1'b1, 16'h0100 + 16'(4 * i), 1'b1, 32'h0, 4'h0));
        exp_cmd.push_back(mk_cmd(1'b0, 16'h0204, 1'b1, 32'h0, 4'h0));
        for (int i = 0; i < 8; i++) exp_lsu_rsp.push_back({16'hC0DE, 16'h0100 + 16'(4 * i)});
        exp_ifu_rsp.push_back(32'hC0DE_0200);
        exp_ifu_rsp.push_back(32'hC0DE_0204);
        fork
            lsu_stream(8, 16'h0100, 1'b1, 32'h0, 4'h0);
            ifu_stream(2, 16'h0200);
            begin
                int base_hs;
                base_hs = n_cmd_hs;
                repeat (10) @(negedge clk);
                #1;
                check("t4_throughput", 64'(n_cmd_hs - base_hs), 64'd10);
            end
        join
        repeat (3) step();

        // LSU owner stalls its response: everything waits, then rsp + next cmd together
        exp_cmd.push_back(mk_cmd(1'b1, 16'h0040, 1'b1, 32'h0, 4'h0));
        exp_cmd.push_back(mk_cmd(1'b0, 16'h0050, 1'b1, 32'h0, 4'h0));
        exp_lsu_rsp.push_back(32'hC0DE_0040);
        exp_ifu_rsp.push_back(32'hC0DE_0050);
        lsu2itcm_rsp_ready = 1'b0;
        lsu2itcm_cmd_valid = 1'b1;
        lsu2itcm_cmd_addr  = 16'h0040;
        lsu2itcm_cmd_read  = 1'b1;
        ifu2itcm_cmd_valid = 1'b1;
        ifu2itcm_cmd_addr  = 16'h0050;
        @(negedge clk);
        check("t5_lsu_ready", 64'(lsu2itcm_cmd_ready), 64'd1);
        step();
        lsu2itcm_cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t5_stall", 64'({itcm_rsp_ready, itcm_cmd_valid, ifu2itcm_cmd_ready, lsu2itcm_rsp_valid}), 64'b0001);
            step();
        end
        lsu2itcm_rsp_ready = 1'b1;
        @(negedge clk);
        check("t5_release", 64'({itcm_rsp_ready, itcm_cmd_valid, ifu2itcm_cmd_ready, lsu2itcm_rsp_valid}), 64'b1111);
        step();
        ifu2itcm_cmd_valid = 1'b0;
        repeat (3) step();

        // Reset while a response is pending
        ifu2itcm_rsp_ready = 1'b0;
        exp_cmd.push_back(mk_cmd(1'b0, 16'h0060, 1'b1, 32'h0, 4'h0));
        ifu2itcm_cmd_valid = 1'b1;
        ifu2itcm_cmd_addr  = 16'h0060;
        step();
        ifu2itcm_cmd_valid = 1'b0;
        #1;
        check("t6_pending", 64'(ifu2itcm_rsp_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        ifu2itcm_cmd_valid = 1'b1;
        ifu2itcm_cmd_addr  = 16'h0070;
        #1;
        check("t6_reset_outputs", 64'(quiet_vec()), 64'd0);
        exp_cmd.push_back(mk_cmd(1'b0, 16'h0070, 1'b1, 32'h0, 4'h0));
        exp_ifu_rsp.push_back(32'hC0DE_0070);
        repeat (2) step();
        rst_n = 1'b1;
        ifu2itcm_rsp_ready = 1'b1;
        @(negedge clk);
        check("t6_first_cmd", 64'(ifu2itcm_cmd_ready), 64'd1);
        check("t6_stale_rsp", 64'(ifu2itcm_rsp_valid), 64'd0);
        step();
        ifu2itcm_cmd_valid = 1'b0;

        for (int i = 0; i < 50 && (exp_cmd.size() + exp_ifu_rsp.size() + exp_lsu_rsp.size()) != 0; i++) step();
        repeat (2) step();
        check("drain_cmd", 64'(exp_cmd.size()), 64'd0);
        check("drain_ifu_rsp", 64'(exp_ifu_rsp.size()), 64'd0);
        check("drain_lsu_rsp", 64'(exp_lsu_rsp.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/itcm_arbt.md
ITCM_ARBT -- requirements
Module: itcm_arbt

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 4: consecutive LSU grants allowed while IFU waits before IFU is forced a grant.
REQ-002 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have IFU ports: ifu2itcm_cmd_valid in 1, ifu2itcm_cmd_ready out 1, ifu2itcm_cmd_addr in `ITCM_ADDR_WIDTH; ifu2itcm_rsp_valid out 1, ifu2itcm_rsp_ready in 1, ifu2itcm_rsp_rdata out `ITCM_RAM_DW. IFU commands are always reads.
REQ-005 SHALL have LSU ports: lsu2itcm_cmd_valid in 1, lsu2itcm_cmd_ready out 1, lsu2itcm_cmd_addr in `ITCM_ADDR_WIDTH, lsu2itcm_cmd_read in 1 (1=read), lsu2itcm_cmd_wdata in `ITCM_RAM_DW, lsu2itcm_cmd_wmask in `ITCM_RAM_DW/8; lsu2itcm_rsp_valid out 1, lsu2itcm_rsp_ready in 1, lsu2itcm_rsp_rdata out `ITCM_RAM_DW.
REQ-006 SHALL have ITCM ports: itcm_cmd_valid out 1, itcm_cmd_ready in 1, itcm_cmd_addr out `ITCM_ADDR_WIDTH, itcm_cmd_read out 1, itcm_cmd_wdata out `ITCM_RAM_DW, itcm_cmd_wmask out `ITCM_RAM_DW/8; itcm_rsp_valid in 1, itcm_rsp_ready out 1, itcm_rsp_rdata in `ITCM_RAM_DW.

Function
REQ-007 SHALL allow at most one outstanding ITCM transaction (cmd handshaken, rsp not yet handshaken).
REQ-008 SHALL track state IDLE (nothing outstanding) and BUSY (one outstanding); IDLE->BUSY on itcm cmd handshake; BUSY->IDLE on itcm rsp handshake with no cmd handshake same cycle; BUSY stays BUSY when rsp and new cmd handshake in same cycle.
REQ-009 SHALL present a command downstream (itcm_cmd_valid=1) only when IDLE, or when BUSY and the current response handshakes this cycle.
REQ-010 SHALL grant combinationally among valid requesters: LSU wins by default; IFU wins if only IFU valid or starvation counter equals STARVE_LIM.
REQ-011 SHALL drive the granted requester's cmd_ready = itcm_cmd_ready gated by REQ-009; non-granted cmd_ready=0.
REQ-012 SHALL mux granted addr/read/wdata/wmask to itcm_cmd_*; IFU grant forces itcm_cmd_read=1, wdata=0, wmask=0.
REQ-013 SHALL register owner (0=IFU, 1=LSU) on each itcm cmd handshake.
REQ-014 SHALL route itcm_rsp_valid and rdata only to the owner's rsp port, the other rsp_valid=0; itcm_rsp_ready = owner's rsp_ready; all rsp_valid=0 when IDLE.
REQ-015 SHALL return LSU write responses (rdata don't-care) exactly like reads.
REQ-016 Starvation counter (width clog2(STARVE_LIM+1)): +1 on LSU grant handshake while ifu2itcm_cmd_valid=1; cleared on IFU handshake or when ifu2itcm_cmd_valid=0; saturates at STARVE_LIM.
REQ-017 SHALL not change grant while a command is valid but not ready (grant recomputed only from current inputs; requesters hold valid/payload until ready per handshake rule).
REQ-018 Minimum latency: cmd accepted same cycle as request when IDLE and itcm_cmd_ready=1; response combinational pass-through from itcm_rsp_valid.
REQ-019 Back-to-back: one transaction per cycle sustained when ITCM returns rsp next cycle and owner rsp_ready=1.

Reset
REQ-020 rst_n low SHALL asynchronously force state IDLE, owner=0, starvation counter=0; all *_valid and *_ready outputs 0 while rst_n low.
REQ-021 Reset mid-transaction SHALL discard the outstanding response; first post-reset cycle behaves as IDLE.

Structure
REQ-022 Widths SHALL come from defines.v (`ITCM_ADDR_WIDTH, `ITCM_RAM_DW); owner encodings and state encodings SHALL be defined there as `ITCM_OWNER_IFU/LSU, `ITCM_ARB_IDLE/BUSY.
REQ-023 Design SHALL be a single module; no sub-module.

Verification
REQ-024 IFU only, addr 0x10, itcm_cmd_ready=1, rsp next cycle rdata 0x00000013 -> ifu2itcm_rsp_rdata=0x00000013, lsu2itcm_rsp_valid=0.
REQ-025 IFU and LSU valid same cycle, LSU write addr 0x20 wdata 0xDEADBEEF wmask 0xF -> LSU granted, itcm_cmd_read=0, ifu2itcm_cmd_ready=0.
REQ-026 Both continuously valid, STARVE_LIM=4 -> grant sequence LSU,LSU,LSU,LSU,IFU repeating.
REQ-027 Owner LSU, lsu2itcm_rsp_ready=0 for 3 cycles -> itcm_rsp_ready=0, no new itcm cmd, IFU stalled; ready=1 -> rsp and next cmd same cycle.
REQ-028 rst_n asserted while BUSY -> all valids 0 immediately; after release, new IFU cmd accepted first cycle, stale itcm_rsp_valid not forwarded.
